// File: rtl/if_stage_if.sv
// Fetch-stage bundle: ROM fetch port, redirect/halt controls and the
// instruction handshake toward decode.
interface if_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] if2rom_ins_o;
  logic [DATA_W-1:0] rom2if_ins_i;
  logic              redirect_valid_i;
  logic [ADDR_W-1:0] redirect_pc_i;
  logic              halt_i;
  logic              id_ready_i;
  logic              if_valid_o;
  logic [DATA_W-1:0] if_ins_o;
  logic [ADDR_W-1:0] if_pc_o;
  logic [1:0]        if_cnt_o;

  modport master (
    output if2rom_ins_o, if_valid_o, if_ins_o, if_pc_o, if_cnt_o,
    input  rom2if_ins_i, redirect_valid_i, redirect_pc_i, halt_i, id_ready_i
  );

  modport slave (
    input  if2rom_ins_o, if_valid_o, if_ins_o, if_pc_o, if_cnt_o,
    output rom2if_ins_i, redirect_valid_i, redirect_pc_i, halt_i, id_ready_i
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register feeding a combinational ROM and a
// 2-entry {pc, instruction} prefetch buffer drained by decode.
module if_stage #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input logic         clk,
  input logic         rest,
  if_stage_if.master  bus
);

  localparam logic [1:0]        FULL_CNT   = 2'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(32'd4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(32'd3);

  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] fifo_pc_r  [2];
  logic [DATA_W-1:0] fifo_ins_r [2];
  logic              wr_ptr_r;
  logic              rd_ptr_r;
  logic [1:0]        cnt_r;
  logic              deq_s;
  logic              enq_s;

  // Handshake decode: a redirect cancels both the decode accept and the fetch.
  always_comb begin
    deq_s = 1'b0;
    enq_s = 1'b0;
    if (bus.redirect_valid_i) begin
      deq_s = 1'b0;
      enq_s = 1'b0;
    end else begin
      deq_s = (cnt_r != 2'd0) && bus.id_ready_i;
      enq_s = !bus.halt_i && ((cnt_r < FULL_CNT) || deq_s);
    end
  end

  assign bus.if2rom_ins_o = pc_r;
  assign bus.if_valid_o   = (cnt_r != 2'd0);
  assign bus.if_ins_o     = fifo_ins_r[rd_ptr_r];
  assign bus.if_pc_o      = fifo_pc_r[rd_ptr_r];
  assign bus.if_cnt_o     = cnt_r;

  // PC, buffer storage, pointers and occupancy; reset clears storage so the
  // head outputs read zero until the first fetch lands.
  always_ff @(posedge clk) begin
    if (!rest) begin
      pc_r     <= RESET_PC;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      cnt_r    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_pc_r[i]  <= '0;
        fifo_ins_r[i] <= '0;
      end
    end else if (bus.redirect_valid_i) begin
      pc_r     <= bus.redirect_pc_i & ALIGN_MASK;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      cnt_r    <= 2'd0;
    end else begin
      if (enq_s) begin
        fifo_pc_r[wr_ptr_r]  <= pc_r;
        fifo_ins_r[wr_ptr_r] <= bus.rom2if_ins_i;
        wr_ptr_r             <= ~wr_ptr_r;
        pc_r                 <= pc_r + PC_STEP;
      end
      if (deq_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({enq_s, deq_s})
        2'b10:   cnt_r <= cnt_r + 2'd1;
        2'b01:   cnt_r <= cnt_r - 2'd1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Scenario bench for if_stage: expected {pc, instruction} pairs are queued as
// stimulus is applied and popped as the buffer head presents them.
module tb_if_stage;

  logic        clk;
  logic        rest;
  logic [31:0] rom_key;
  logic [63:0] sb_q [$];
  logic [63:0] exp_e;
  logic [34:0] stat_s;
  int          n_vec;
  int          n_miss;

  if_stage_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  if_stage #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk  (clk),
    .rest (rest),
    .bus  (bus)
  );

  assign bus.rom2if_ins_i = bus.if2rom_ins_o ^ rom_key;
  assign stat_s = {bus.if_valid_o, bus.if_cnt_o, bus.if2rom_ins_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rest                 = 1'b0;
    bus.redirect_valid_i = 1'b0;
    bus.redirect_pc_i    = 32'h0;
    bus.halt_i           = 1'b0;
    bus.id_ready_i       = 1'b0;
    rom_key              = 32'hC0DE_0000;
    repeat (2) @(posedge clk);
    #1;
    sb_q.delete();
  endtask

  task automatic test_reset();
    rest                 = 1'b0;
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 32'h40;
    bus.halt_i           = 1'b0;
    bus.id_ready_i       = 1'b1;
    rom_key              = 32'hC0DE_0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (stat_s !== {1'b0, 2'd0, 32'h0}) begin
      n_miss++;
      $display("FAIL reset_status: got v/cnt/fetch=%h want %h", stat_s, {1'b0, 2'd0, 32'h0});
    end
    n_vec++;
    if ({bus.if_pc_o, bus.if_ins_o} !== 64'h0) begin
      n_miss++;
      $display("FAIL reset_head: got pc=%h ins=%h want 0/0", bus.if_pc_o, bus.if_ins_o);
    end
    bus.redirect_valid_i = 1'b0;
    bus.id_ready_i       = 1'b0;
  endtask

  task automatic test_stream();
    do_reset();
    rom_key        = 32'h0;
    rest           = 1'b1;
    bus.id_ready_i = 1'b1;
    for (int a = 0; a < 16; a += 4) sb_q.push_back({32'(a), 32'(a)});
    @(negedge clk);
    n_vec++;
    if (stat_s !== {1'b0, 2'd0, 32'h0}) begin
      n_miss++;
      $display("FAIL stream_first: got %h want %h", stat_s, {1'b0, 2'd0, 32'h0});
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_e = sb_q.pop_front();
      n_vec++;
      if ({bus.if_valid_o, bus.if_pc_o, bus.if_ins_o} !== {1'b1, exp_e}) begin
        n_miss++;
        $display("FAIL stream_out: got v=%b pc=%h ins=%h want pc=%h ins=%h",
                 bus.if_valid_o, bus.if_pc_o, bus.if_ins_o, exp_e[63:32], exp_e[31:0]);
      end
    end
    @(posedge clk); #1;
    bus.id_ready_i = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    rest = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (stat_s !== {1'b1, 2'd1, 32'h4}) begin
      n_miss++;
      $display("FAIL stall_cnt1: got %h want %h", stat_s, {1'b1, 2'd1, 32'h4});
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if ({stat_s, bus.if_pc_o, bus.if_ins_o} !== {1'b1, 2'd2, 32'h8, 32'h0, 32'hC0DE_0000}) begin
      n_miss++;
      $display("FAIL stall_full: got st=%h pc=%h ins=%h want st=%h pc=0 ins=c0de0000",
               stat_s, bus.if_pc_o, bus.if_ins_o, {1'b1, 2'd2, 32'h8});
    end
    @(posedge clk); #1;
    for (int a = 0; a < 12; a += 4) sb_q.push_back({32'(a), 32'(a) ^ rom_key});
    bus.id_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp_e = sb_q.pop_front();
      n_vec++;
      if ({bus.if_valid_o, bus.if_pc_o, bus.if_ins_o} !== {1'b1, exp_e}) begin
        n_miss++;
        $display("FAIL stall_drain: got v=%b pc=%h ins=%h want pc=%h ins=%h",
                 bus.if_valid_o, bus.if_pc_o, bus.if_ins_o, exp_e[63:32], exp_e[31:0]);
      end
    end
    @(posedge clk); #1;
    bus.id_ready_i = 1'b0;
    @(negedge clk);
    n_vec++;
    if (stat_s !== {1'b1, 2'd2, 32'h14}) begin
      n_miss++;
      $display("FAIL stall_after: got %h want %h", stat_s, {1'b1, 2'd2, 32'h14});
    end
  endtask

  task automatic test_redirect_full();
    do_reset();
    rest = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 32'h103;
    @(negedge clk);
    n_vec++;
    if (stat_s !== {1'b1, 2'd2, 32'h8}) begin
      n_miss++;
      $display("FAIL redir_pre: got %h want %h", stat_s, {1'b1, 2'd2, 32'h8});
    end
    @(posedge clk); #1;
    bus.redirect_valid_i = 1'b0;
    bus.id_ready_i       = 1'b1;
    sb_q.push_back({32'h100, 32'h100 ^ rom_key});
    @(negedge clk);
    n_vec++;
    if (stat_s !== {1'b0, 2'd0, 32'h100}) begin
      n_miss++;
      $display("FAIL redir_flush: got %h want %h", stat_s, {1'b0, 2'd0, 32'h100});
    end
    @(negedge clk);
    exp_e = sb_q.pop_front();
    n_vec++;
    if ({bus.if_valid_o, bus.if_pc_o, bus.if_ins_o} !== {1'b1, exp_e}) begin
      n_miss++;
      $display("FAIL redir_target: got v=%b pc=%h ins=%h want pc=%h ins=%h",
               bus.if_valid_o, bus.if_pc_o, bus.if_ins_o, exp_e[63:32], exp_e[31:0]);
    end
    @(posedge clk); #1;
    bus.id_ready_i = 1'b0;
  endtask

  task automatic test_redirect_deq();
    do_reset();
    rest = 1'b1;
    @(posedge clk); #1;
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 32'h200;
    bus.id_ready_i       = 1'b1;
    @(negedge clk);
    n_vec++;
    if (stat_s !== {1'b1, 2'd1, 32'h4}) begin
      n_miss++;
      $display("FAIL rdq_pre: got %h want %h", stat_s, {1'b1, 2'd1, 32'h4});
    end
    @(posedge clk); #1;
    bus.redirect_valid_i = 1'b0;
    bus.id_ready_i       = 1'b0;
    sb_q.push_back({32'h200, 32'h200 ^ rom_key});
    @(negedge clk);
    n_vec++;
    if (stat_s !== {1'b0, 2'd0, 32'h200}) begin
      n_miss++;
      $display("FAIL rdq_flush: got %h want %h", stat_s, {1'b0, 2'd0, 32'h200});
    end
    @(negedge clk);
    exp_e = sb_q.pop_front();
    n_vec++;
    if ({bus.if_valid_o, bus.if_cnt_o, bus.if_pc_o, bus.if_ins_o} !== {1'b1, 2'd1, exp_e}) begin
      n_miss++;
      $display("FAIL rdq_head: got v=%b cnt=%0d pc=%h ins=%h want cnt=1 pc=%h ins=%h",
               bus.if_valid_o, bus.if_cnt_o, bus.if_pc_o, bus.if_ins_o, exp_e[63:32], exp_e[31:0]);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    rest                 = 1'b1;
    bus.id_ready_i       = 1'b1;
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 32'hFFFF_FFFC;
    @(posedge clk); #1;
    bus.redirect_valid_i = 1'b0;
    sb_q.push_back({32'hFFFF_FFFC, 32'hFFFF_FFFC ^ rom_key});
    sb_q.push_back({32'h0, 32'h0 ^ rom_key});
    sb_q.push_back({32'h4, 32'h4 ^ rom_key});
    @(negedge clk);
    n_vec++;
    if (stat_s !== {1'b0, 2'd0, 32'hFFFF_FFFC}) begin
      n_miss++;
      $display("FAIL wrap_pc: got %h want %h", stat_s, {1'b0, 2'd0, 32'hFFFF_FFFC});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp_e = sb_q.pop_front();
      n_vec++;
      if ({bus.if_valid_o, bus.if_pc_o, bus.if_ins_o} !== {1'b1, exp_e}) begin
        n_miss++;
        $display("FAIL wrap_out: got v=%b pc=%h ins=%h want pc=%h ins=%h",
                 bus.if_valid_o, bus.if_pc_o, bus.if_ins_o, exp_e[63:32], exp_e[31:0]);
      end
    end
    @(posedge clk); #1;
    bus.id_ready_i = 1'b0;
  endtask

  task automatic test_halt();
    do_reset();
    rest = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    bus.halt_i     = 1'b1;
    bus.id_ready_i = 1'b1;
    sb_q.push_back({32'h0, 32'h0 ^ rom_key});
    sb_q.push_back({32'h4, 32'h4 ^ rom_key});
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      exp_e = sb_q.pop_front();
      n_vec++;
      if ({bus.if_valid_o, bus.if_pc_o, bus.if_ins_o} !== {1'b1, exp_e}) begin
        n_miss++;
        $display("FAIL halt_drain: got v=%b pc=%h ins=%h want pc=%h ins=%h",
                 bus.if_valid_o, bus.if_pc_o, bus.if_ins_o, exp_e[63:32], exp_e[31:0]);
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++;
    if (stat_s !== {1'b0, 2'd0, 32'h8}) begin
      n_miss++;
      $display("FAIL halt_empty: got %h want %h", stat_s, {1'b0, 2'd0, 32'h8});
    end
    @(posedge clk); #1;
    bus.halt_i = 1'b0;
    sb_q.push_back({32'h8, 32'h8 ^ rom_key});
    @(negedge clk);
    @(negedge clk);
    exp_e = sb_q.pop_front();
    n_vec++;
    if ({bus.if_valid_o, bus.if_pc_o, bus.if_ins_o} !== {1'b1, exp_e}) begin
      n_miss++;
      $display("FAIL halt_resume: got v=%b pc=%h ins=%h want pc=%h ins=%h",
               bus.if_valid_o, bus.if_pc_o, bus.if_ins_o, exp_e[63:32], exp_e[31:0]);
    end
    @(posedge clk); #1;
    bus.id_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    rest = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rest                 = 1'b0;
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 32'h300;
    bus.halt_i           = 1'b1;
    bus.id_ready_i       = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++;
    if ({stat_s, bus.if_pc_o, bus.if_ins_o} !== {1'b0, 2'd0, 32'h0, 64'h0}) begin
      n_miss++;
      $display("FAIL reset_mid: got st=%h pc=%h ins=%h want all zero",
               stat_s, bus.if_pc_o, bus.if_ins_o);
    end
    bus.redirect_valid_i = 1'b0;
    bus.halt_i           = 1'b0;
    bus.id_ready_i       = 1'b0;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_full();
    test_redirect_deq();
    test_wrap();
    test_halt();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
